// File: rtl/operand_fetch_scoreboard.sv
// operand_fetch_scoreboard
//   Issue stage between decode and execute. Holds the architectural register
//   file and a one-bit-per-register busy scoreboard. It stalls an instruction
//   while any of its sources or destinations is busy. It reads operands with
//   forwarding from the writeback port. Accepted instructions land in a
//   one-entry output register that execute drains with a valid/ready handshake.
module operand_fetch_scoreboard #(
  parameter int                 NREGS    = 16,
  parameter int                 DATA_W   = 64,
  parameter int                 RIP_W    = 32,
  parameter int                 SP_INDEX = 4,
  parameter logic [DATA_W-1:0]  SP_RESET = 64'h0
) (
  input  logic                clk,
  input  logic                reset_n,
  // decode side
  input  logic                issueValidIn,
  output logic                issueReadyOut,
  input  logic [RIP_W-1:0]    ripIn,
  input  logic [3:0]          src1In,
  input  logic [3:0]          src2In,
  input  logic                src1ValidIn,
  input  logic                src2ValidIn,
  input  logic [3:0]          destIn,
  input  logic [3:0]          destSpecialIn,
  input  logic                destSpecialValidIn,
  // writeback side
  input  logic                wbValidIn,
  input  logic [3:0]          wbDestIn,
  input  logic [DATA_W-1:0]   wbResultIn,
  input  logic [3:0]          wbDestSpecialIn,
  input  logic                wbDestSpecialValidIn,
  input  logic [DATA_W-1:0]   wbResultSpecialIn,
  // execute side
  output logic                exValidOut,
  input  logic                exReadyIn,
  output logic [RIP_W-1:0]    ripOut,
  output logic [3:0]          src1Out,
  output logic [3:0]          src2Out,
  output logic                src1ValidOut,
  output logic                src2ValidOut,
  output logic [3:0]          destOut,
  output logic [3:0]          destSpecialOut,
  output logic                destSpecialValidOut,
  output logic [DATA_W-1:0]   operand1Out,
  output logic [DATA_W-1:0]   operand2Out,
  // status
  output logic [NREGS-1:0]    busyMapOut,
  output logic [31:0]         stallCountOut
);

  localparam logic [31:0] STALL_MAX = 32'hFFFF_FFFF;

  logic [DATA_W-1:0] regFile [NREGS];

  logic [NREGS-1:0]  wbClr;
  logic [NREGS-1:0]  busyEff;
  logic [NREGS-1:0]  setMask;
  logic              hazard;
  logic              accept;
  logic [DATA_W-1:0] operand1Next;
  logic [DATA_W-1:0] operand2Next;

  // One-hot decode of a register index.
  function automatic logic [NREGS-1:0] oneHot(input logic [3:0] idx);
    logic [NREGS-1:0] v;
    v = {NREGS{1'b0}};
    v[idx] = 1'b1;
    return v;
  endfunction

  // Operand read. A retiring primary result beats a retiring special result,
  // which beats the stored value. An unused source reads as zero.
  function automatic logic [DATA_W-1:0] readOperand(
    input logic              used,
    input logic [3:0]        idx,
    input logic [DATA_W-1:0] rfVal,
    input logic              wbValid,
    input logic [3:0]        wbDest,
    input logic [DATA_W-1:0] wbVal,
    input logic              wbSpecValid,
    input logic [3:0]        wbSpecDest,
    input logic [DATA_W-1:0] wbSpecVal
  );
    logic [DATA_W-1:0] r;
    if (!used) begin
      r = {DATA_W{1'b0}};
    end else if (wbValid && (wbDest == idx)) begin
      r = wbVal;
    end else if (wbValid && wbSpecValid && (wbSpecDest == idx)) begin
      r = wbSpecVal;
    end else begin
      r = rfVal;
    end
    return r;
  endfunction

  // Scoreboard view with this cycle's writeback already retired.
  // Hazard detection and issue handshake are built on that view.
  always_comb begin
    wbClr   = {NREGS{1'b0}};
    setMask = {NREGS{1'b0}};
    if (wbValidIn) begin
      wbClr = oneHot(wbDestIn);
      if (wbDestSpecialValidIn) begin
        wbClr = wbClr | oneHot(wbDestSpecialIn);
      end else begin
        wbClr = wbClr;
      end
    end else begin
      wbClr = {NREGS{1'b0}};
    end
    busyEff = busyMapOut & ~wbClr;
    // A busy destination also stalls: one busy bit cannot track two writers.
    hazard  = (src1ValidIn & busyEff[src1In])
            | (src2ValidIn & busyEff[src2In])
            | busyEff[destIn]
            | (destSpecialValidIn & busyEff[destSpecialIn]);
    issueReadyOut = (!exValidOut || exReadyIn) && !hazard;
    accept        = issueValidIn && issueReadyOut;
    if (accept) begin
      setMask = oneHot(destIn);
      if (destSpecialValidIn) begin
        setMask = setMask | oneHot(destSpecialIn);
      end else begin
        setMask = setMask;
      end
    end else begin
      setMask = {NREGS{1'b0}};
    end
  end

  // Source operand values, including same-cycle writeback forwarding.
  always_comb begin
    operand1Next = readOperand(src1ValidIn, src1In, regFile[src1In], wbValidIn, wbDestIn,
                               wbResultIn, wbDestSpecialValidIn, wbDestSpecialIn, wbResultSpecialIn);
    operand2Next = readOperand(src2ValidIn, src2In, regFile[src2In], wbValidIn, wbDestIn,
                               wbResultIn, wbDestSpecialValidIn, wbDestSpecialIn, wbResultSpecialIn);
  end

  // Register file. The special write is issued first, so a primary write to
  // the same index overrides it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) begin
        regFile[i] <= (i == SP_INDEX) ? SP_RESET : {DATA_W{1'b0}};
      end
    end else if (wbValidIn) begin
      if (wbDestSpecialValidIn) begin
        regFile[wbDestSpecialIn] <= wbResultSpecialIn;
      end
      regFile[wbDestIn] <= wbResultIn;
    end
  end

  // Busy bitmap. A new issue sets its bits after the retiring writeback has
  // cleared its bits, so the set wins on a shared index.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busyMapOut <= {NREGS{1'b0}};
    end else begin
      busyMapOut <= (busyMapOut & ~wbClr) | setMask;
    end
  end

  // One-entry output register toward execute. The payload is held while
  // execute stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      exValidOut          <= 1'b0;
      ripOut              <= {RIP_W{1'b0}};
      src1Out             <= 4'd0;
      src2Out             <= 4'd0;
      src1ValidOut        <= 1'b0;
      src2ValidOut        <= 1'b0;
      destOut             <= 4'd0;
      destSpecialOut      <= 4'd0;
      destSpecialValidOut <= 1'b0;
      operand1Out         <= {DATA_W{1'b0}};
      operand2Out         <= {DATA_W{1'b0}};
    end else if (accept) begin
      exValidOut          <= 1'b1;
      ripOut              <= ripIn;
      src1Out             <= src1In;
      src2Out             <= src2In;
      src1ValidOut        <= src1ValidIn;
      src2ValidOut        <= src2ValidIn;
      destOut             <= destIn;
      destSpecialOut      <= destSpecialIn;
      destSpecialValidOut <= destSpecialValidIn;
      operand1Out         <= operand1Next;
      operand2Out         <= operand2Next;
    end else if (exReadyIn) begin
      exValidOut          <= 1'b0;
    end
  end

  // Saturating count of cycles in which decode was held off.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stallCountOut <= 32'd0;
    end else if (issueValidIn && !issueReadyOut && (stallCountOut != STALL_MAX)) begin
      stallCountOut <= stallCountOut + 32'd1;
    end
  end

endmodule

// File: tb/tb_operand_fetch_scoreboard.sv
// Directed bench for operand_fetch_scoreboard with hand-computed expectations.
module tb_operand_fetch_scoreboard;

  logic        clk;
  logic        reset_n;
  logic        issueValidIn;
  logic        issueReadyOut;
  logic [31:0] ripIn;
  logic [3:0]  src1In, src2In;
  logic        src1ValidIn, src2ValidIn;
  logic [3:0]  destIn, destSpecialIn;
  logic        destSpecialValidIn;
  logic        wbValidIn;
  logic [3:0]  wbDestIn, wbDestSpecialIn;
  logic [63:0] wbResultIn, wbResultSpecialIn;
  logic        wbDestSpecialValidIn;
  logic        exValidOut;
  logic        exReadyIn;
  logic [31:0] ripOut;
  logic [3:0]  src1Out, src2Out, destOut, destSpecialOut;
  logic        src1ValidOut, src2ValidOut, destSpecialValidOut;
  logic [63:0] operand1Out, operand2Out;
  logic [15:0] busyMapOut;
  logic [31:0] stallCountOut;

  int errCount;
  int checkCount;

  operand_fetch_scoreboard #(.SP_RESET(64'h8000)) dut (
    .clk(clk), .reset_n(reset_n),
    .issueValidIn(issueValidIn), .issueReadyOut(issueReadyOut), .ripIn(ripIn),
    .src1In(src1In), .src2In(src2In), .src1ValidIn(src1ValidIn), .src2ValidIn(src2ValidIn),
    .destIn(destIn), .destSpecialIn(destSpecialIn), .destSpecialValidIn(destSpecialValidIn),
    .wbValidIn(wbValidIn), .wbDestIn(wbDestIn), .wbResultIn(wbResultIn),
    .wbDestSpecialIn(wbDestSpecialIn), .wbDestSpecialValidIn(wbDestSpecialValidIn),
    .wbResultSpecialIn(wbResultSpecialIn),
    .exValidOut(exValidOut), .exReadyIn(exReadyIn), .ripOut(ripOut),
    .src1Out(src1Out), .src2Out(src2Out), .src1ValidOut(src1ValidOut), .src2ValidOut(src2ValidOut),
    .destOut(destOut), .destSpecialOut(destSpecialOut), .destSpecialValidOut(destSpecialValidOut),
    .operand1Out(operand1Out), .operand2Out(operand2Out),
    .busyMapOut(busyMapOut), .stallCountOut(stallCountOut)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] rip, input logic [3:0] s1, input logic v1,
                       input logic [3:0] s2, input logic v2, input logic [3:0] d,
                       input logic [3:0] ds, input logic dsv);
    issueValidIn = 1'b1; ripIn = rip;
    src1In = s1; src1ValidIn = v1; src2In = s2; src2ValidIn = v2;
    destIn = d; destSpecialIn = ds; destSpecialValidIn = dsv;
  endtask

  task automatic wb(input logic [3:0] d, input logic [63:0] v, input logic [3:0] ds,
                    input logic dsv, input logic [63:0] sv);
    wbValidIn = 1'b1; wbDestIn = d; wbResultIn = v;
    wbDestSpecialIn = ds; wbDestSpecialValidIn = dsv; wbResultSpecialIn = sv;
  endtask

  initial begin
    errCount = 0; checkCount = 0;
    reset_n = 1'b0;
    issueValidIn = 1'b0; ripIn = 32'd0;
    src1In = 4'd0; src2In = 4'd0; src1ValidIn = 1'b0; src2ValidIn = 1'b0;
    destIn = 4'd0; destSpecialIn = 4'd0; destSpecialValidIn = 1'b0;
    wbValidIn = 1'b0; wbDestIn = 4'd0; wbResultIn = 64'd0;
    wbDestSpecialIn = 4'd0; wbDestSpecialValidIn = 1'b0; wbResultSpecialIn = 64'd0;
    exReadyIn = 1'b1;
    #1;
    checkVal("rst_busy", busyMapOut, 64'h0);
    checkVal("rst_exvalid", exValidOut, 64'h0);
    checkVal("rst_stall", stallCountOut, 64'h0);
    checkVal("rst_rip", ripOut, 64'h0);
    step(); step();
    reset_n = 1'b1;

    // r0 <- r4 : r4 holds the SP reset value
    issue(32'h10, 4'd4, 1'b1, 4'd0, 1'b0, 4'd0, 4'd0, 1'b0);
    #1 checkVal("sp_ready", issueReadyOut, 64'h1);
    step();
    checkVal("sp_exvalid", exValidOut, 64'h1);
    checkVal("sp_op1", operand1Out, 64'h8000);
    checkVal("sp_op2", operand2Out, 64'h0);
    checkVal("sp_rip", ripOut, 64'h10);
    checkVal("sp_busy", busyMapOut, 64'h0001);

    // Load r2/r3 through writeback to non-busy registers
    issueValidIn = 1'b0;
    wb(4'd2, 64'h11, 4'd3, 1'b1, 64'h22);
    step();
    checkVal("drain_exvalid", exValidOut, 64'h0);
    checkVal("drain_busy", busyMapOut, 64'h0001);

    // r1 <- r2,r3 while r0 retires
    wb(4'd0, 64'h99, 4'd0, 1'b0, 64'h0);
    issue(32'h20, 4'd2, 1'b1, 4'd3, 1'b1, 4'd1, 4'd0, 1'b0);
    #1 checkVal("r1_ready", issueReadyOut, 64'h1);
    step();
    checkVal("r1_exvalid", exValidOut, 64'h1);
    checkVal("r1_op1", operand1Out, 64'h11);
    checkVal("r1_op2", operand2Out, 64'h22);
    checkVal("r1_dest", destOut, 64'h1);
    checkVal("r1_busy", busyMapOut, 64'h0002);

    // r4 <- r1 while r1 busy: stall 3 cycles, then forward from writeback
    wbValidIn = 1'b0;
    issue(32'h30, 4'd1, 1'b1, 4'd0, 1'b0, 4'd4, 4'd0, 1'b0);
    #1 checkVal("raw_ready", issueReadyOut, 64'h0);
    step(); step(); step();
    checkVal("raw_stall", stallCountOut, 64'd3);
    checkVal("raw_ready2", issueReadyOut, 64'h0);
    checkVal("raw_exvalid", exValidOut, 64'h0);
    wb(4'd1, 64'h55, 4'd0, 1'b0, 64'h0);
    #1 checkVal("fwd_ready", issueReadyOut, 64'h1);
    step();
    checkVal("fwd_exvalid", exValidOut, 64'h1);
    checkVal("fwd_op1", operand1Out, 64'h55);
    checkVal("fwd_busy", busyMapOut, 64'h0010);
    checkVal("fwd_stall", stallCountOut, 64'd3);
    checkVal("fwd_rip", ripOut, 64'h30);

    // Execute backpressure: payload held 5 cycles, then accept with no bubble
    wbValidIn = 1'b0;
    exReadyIn = 1'b0;
    issue(32'h40, 4'd2, 1'b1, 4'd0, 1'b0, 4'd5, 4'd0, 1'b0);
    #1 checkVal("bp_ready", issueReadyOut, 64'h0);
    for (int i = 0; i < 5; i++) begin
      step();
      checkVal("bp_rip", ripOut, 64'h30);
      checkVal("bp_op1", operand1Out, 64'h55);
      checkVal("bp_exvalid", exValidOut, 64'h1);
    end
    checkVal("bp_stall", stallCountOut, 64'd8);
    exReadyIn = 1'b1;
    #1 checkVal("bp_release_ready", issueReadyOut, 64'h1);
    step();
    checkVal("bp_new_rip", ripOut, 64'h40);
    checkVal("bp_new_op1", operand1Out, 64'h11);
    checkVal("bp_new_exvalid", exValidOut, 64'h1);
    checkVal("bp_new_busy", busyMapOut, 64'h0030);
    checkVal("bp_new_stall", stallCountOut, 64'd8);

    // Accept dest r6 while writeback clears r6 (and r5): set wins
    issue(32'h50, 4'd3, 1'b1, 4'd0, 1'b0, 4'd6, 4'd0, 1'b0);
    wb(4'd6, 64'h66, 4'd5, 1'b1, 64'h77);
    step();
    checkVal("setwin_busy", busyMapOut, 64'h0050);
    checkVal("setwin_op1", operand1Out, 64'h22);

    // Primary and special writeback to the same index: primary wins
    issue(32'h60, 4'd7, 1'b1, 4'd7, 1'b1, 4'd8, 4'd0, 1'b0);
    wb(4'd7, 64'hA, 4'd7, 1'b1, 64'hB);
    step();
    checkVal("prio_op1", operand1Out, 64'hA);
    checkVal("prio_op2", operand2Out, 64'hA);
    checkVal("prio_busy", busyMapOut, 64'h0150);

    // Stored value of r7 plus secondary destination, unused src2 reads 0
    wbValidIn = 1'b0;
    issue(32'h70, 4'd7, 1'b1, 4'd7, 1'b0, 4'd9, 4'd10, 1'b1);
    step();
    checkVal("rf_op1", operand1Out, 64'hA);
    checkVal("rf_op2", operand2Out, 64'h0);
    checkVal("spec_dest", destSpecialOut, 64'd10);
    checkVal("spec_valid", destSpecialValidOut, 64'h1);
    checkVal("spec_busy", busyMapOut, 64'h0750);

    // Reset asserted mid-stall
    issue(32'h80, 4'd4, 1'b1, 4'd0, 1'b0, 4'd11, 4'd0, 1'b0);
    destSpecialValidIn = 1'b0;
    step(); step();
    checkVal("pre_rst_stall", stallCountOut, 64'd10);
    #2 reset_n = 1'b0;
    #1;
    checkVal("mid_rst_exvalid", exValidOut, 64'h0);
    checkVal("mid_rst_busy", busyMapOut, 64'h0);
    checkVal("mid_rst_stall", stallCountOut, 64'h0);
    checkVal("mid_rst_rip", ripOut, 64'h0);
    issueValidIn = 1'b0;
    step(); step();
    reset_n = 1'b1;

    // Register file is back to reset contents
    issue(32'h90, 4'd4, 1'b1, 4'd7, 1'b1, 4'd0, 4'd0, 1'b0);
    #1 checkVal("post_rst_ready", issueReadyOut, 64'h1);
    step();
    checkVal("post_rst_op1", operand1Out, 64'h8000);
    checkVal("post_rst_op2", operand2Out, 64'h0);
    checkVal("post_rst_busy", busyMapOut, 64'h0001);
    issueValidIn = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errCount, checkCount);
    $finish;
  end

endmodule
